// File: rtl/ahim_config_pkg.sv
// Shared configuration for the AHIM result path: buffer depth, data widths
// and the result FILO controller state type.
package ahim_config_pkg;

  localparam int FILO_DEPTH     = 32;
  localparam int PIO_DATA_WIDTH = 32;
  localparam int UINT8_WIDTH    = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } filo_state_t;

endpackage

// File: rtl/result_filo_if.sv
// Producer/consumer bundle for the result FILO. The master side is the
// frame source and consumer control; the slave side is the buffer itself.
interface result_filo_if #(
  parameter int DW = ahim_config_pkg::PIO_DATA_WIDTH,
  parameter int HW = ahim_config_pkg::UINT8_WIDTH
);
  logic          Clear_buff;
  logic          push;
  logic [DW-1:0] push_data;
  logic          frame_done;
  logic          pop;
  logic          tx_done;
  logic [DW-1:0] filo_q;
  logic [HW-1:0] headcount;
  logic          tx_ready;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  modport master (
    output Clear_buff, push, push_data, frame_done, pop, tx_done,
    input  filo_q, headcount, tx_ready, full, empty, overflow, underflow
  );

  modport slave (
    input  Clear_buff, push, push_data, frame_done, pop, tx_done,
    output filo_q, headcount, tx_ready, full, empty, overflow, underflow
  );
endinterface

// File: rtl/result_filo.sv
// Result line stack: a frame is pushed, closed by frame_done, then popped
// top-first by the consumer until tx_done releases the buffer.
//
// state | meaning
// FILL  | accepting pushes; frame_done with lines stored closes the frame
// READY | frame closed, nothing popped yet; tx_ready asserted
// DRAIN | consumer popping lines; tx_ready asserted until tx_done
module result_filo #(
  parameter int FILO_DEPTH = ahim_config_pkg::FILO_DEPTH
) (
  input logic          clk_in,
  input logic          rst_n,
  result_filo_if.slave bus
);
  import ahim_config_pkg::*;

  localparam int SP_W  = $clog2(FILO_DEPTH) + 1;
  localparam int IDX_W = $clog2(FILO_DEPTH);
  localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(FILO_DEPTH);
  localparam logic [SP_W-1:0] ONE_SP   = SP_W'(1);

  logic [PIO_DATA_WIDTH-1:0] mem [FILO_DEPTH];

  filo_state_t            state, state_nxt;
  logic [SP_W-1:0]        sp, sp_nxt;
  logic [UINT8_WIDTH-1:0] headcount, headcount_nxt;
  logic                   overflow, overflow_nxt;
  logic                   underflow, underflow_nxt;
  logic                   wr_en;
  logic                   full, empty;
  logic [IDX_W-1:0]       top_idx;

  assign full    = (sp == DEPTH_SP);
  assign empty   = (sp == '0);
  assign top_idx = IDX_W'(sp - ONE_SP);

  always_comb begin
    state_nxt     = state;
    sp_nxt        = sp;
    headcount_nxt = headcount;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    wr_en         = 1'b0;

    if (bus.Clear_buff) begin
      state_nxt     = FILL;
      sp_nxt        = '0;
      headcount_nxt = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else if (bus.tx_done && state != FILL) begin
      state_nxt     = FILL;
      sp_nxt        = '0;
      headcount_nxt = '0;
    end else begin
      if (bus.pop) begin
        if (state != FILL && !empty) begin
          sp_nxt = sp - ONE_SP;
          if (state == READY) state_nxt = DRAIN;
        end else begin
          underflow_nxt = 1'b1;
        end
      end
      if (bus.push) begin
        if (state == FILL && !full) begin
          wr_en  = 1'b1;
          sp_nxt = sp + ONE_SP;
        end else begin
          overflow_nxt = 1'b1;
        end
      end
      // sp_nxt already includes a same-cycle push, so it becomes the count
      if (bus.frame_done && state == FILL && sp_nxt != '0) begin
        state_nxt     = READY;
        headcount_nxt = UINT8_WIDTH'(sp_nxt);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      sp        <= '0;
      headcount <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      sp        <= sp_nxt;
      headcount <= headcount_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // Storage carries no reset; the empty mask on filo_q hides stale lines.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[IDX_W'(sp)] <= bus.push_data;
  end

  assign bus.filo_q    = empty ? '0 : mem[top_idx];
  assign bus.headcount = headcount;
  assign bus.tx_ready  = (state != FILL);
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_result_filo.sv
// Self-checking bench for result_filo: directed frame scenarios followed by
// random traffic, all compared against a queue-based stack model.
module tb_result_filo;
  import ahim_config_pkg::*;

  localparam int D = FILO_DEPTH;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  result_filo_if bus ();

  result_filo #(.FILO_DEPTH(D)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [31:0] stk [$];
  bit          m_closed;
  int          m_hc;
  bit          m_ovf;
  bit          m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_q;
    exp_q = (stk.size() > 0) ? stk[$] : 32'h0;
    check({tag, ".filo_q"},    32'(bus.filo_q),    exp_q);
    check({tag, ".headcount"}, 32'(bus.headcount), 32'(m_hc));
    check({tag, ".tx_ready"},  32'(bus.tx_ready),  32'(m_closed));
    check({tag, ".full"},      32'(bus.full),      32'(stk.size() == D));
    check({tag, ".empty"},     32'(bus.empty),     32'(stk.size() == 0));
    check({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    stk.delete();
    m_closed = 1'b0;
    m_hc     = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic model_step(input bit c, tx, ps, p, fd, input logic [31:0] d);
    if (c) begin
      model_reset();
    end else if (tx && m_closed) begin
      stk.delete();
      m_closed = 1'b0;
      m_hc     = 0;
    end else begin
      if (ps) begin
        if (m_closed && stk.size() > 0) void'(stk.pop_back());
        else m_unf = 1'b1;
      end
      if (p) begin
        if (!m_closed && stk.size() < D) stk.push_back(d);
        else m_ovf = 1'b1;
      end
      if (fd && !m_closed && stk.size() > 0) begin
        m_closed = 1'b1;
        m_hc     = stk.size();
      end
    end
  endtask

  task automatic cycle(input string tag, input bit c, tx, ps, p, fd, input logic [31:0] d);
    @(negedge clk_in);
    bus.Clear_buff = c;
    bus.tx_done    = tx;
    bus.pop        = ps;
    bus.push       = p;
    bus.frame_done = fd;
    bus.push_data  = d;
    model_step(c, tx, ps, p, fd, d);
    @(posedge clk_in);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    cycle("idle", 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk_in);
    bus.Clear_buff = 0; bus.tx_done = 0; bus.pop = 0;
    bus.push = 0; bus.frame_done = 0; bus.push_data = '0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.Clear_buff = 0; bus.tx_done = 0; bus.pop = 0;
    bus.push = 0; bus.frame_done = 0; bus.push_data = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 check_all("reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    idle();

    // three-line frame, popped top-first
    cycle("f3.push", 0, 0, 0, 1, 0, 32'hA1);
    cycle("f3.push", 0, 0, 0, 1, 0, 32'hA2);
    cycle("f3.push", 0, 0, 0, 1, 0, 32'hA3);
    cycle("f3.fd",   0, 0, 0, 0, 1, 32'h0);
    check("f3.hc_const", 32'(bus.headcount), 32'd3);
    check("f3.top_const", bus.filo_q, 32'hA3);
    repeat (3) cycle("f3.pop", 0, 0, 1, 0, 0, 32'h0);
    check("f3.empty_const", 32'(bus.empty), 32'd1);
    cycle("f3.tx", 0, 1, 0, 0, 0, 32'h0);

    // fill past capacity
    for (int i = 1; i <= D + 2; i++) cycle("ovf.push", 0, 0, 0, 1, 0, 32'(i) + 32'h100);
    cycle("ovf.fd", 0, 0, 0, 0, 1, 32'h0);
    check("ovf.hc_const", 32'(bus.headcount), 32'(D));
    check("ovf.top_const", bus.filo_q, 32'(D) + 32'h100);
    cycle("ovf.clr", 1, 0, 0, 0, 0, 32'h0);

    // same-cycle push and frame_done
    cycle("pfd.push", 0, 0, 0, 1, 0, 32'h44);
    cycle("pfd.both", 0, 0, 0, 1, 1, 32'h55);
    check("pfd.hc_const", 32'(bus.headcount), 32'd2);
    cycle("pfd.tx", 0, 1, 0, 0, 0, 32'h0);

    // empty frame_done is ignored
    cycle("fd0", 0, 0, 0, 0, 1, 32'h0);

    // tx_done mid-drain discards remaining lines
    for (int i = 0; i < 5; i++) cycle("txd.push", 0, 0, 0, 1, 0, 32'h200 + 32'(i));
    cycle("txd.fd", 0, 0, 0, 0, 1, 32'h0);
    repeat (3) cycle("txd.pop", 0, 0, 1, 0, 0, 32'h0);
    cycle("txd.tx", 0, 1, 0, 0, 0, 32'h0);
    cycle("txd.push77", 0, 0, 0, 1, 0, 32'h77);
    cycle("txd.clr", 1, 0, 0, 0, 0, 32'h0);

    // push in READY, pop while empty in DRAIN
    cycle("err.push", 0, 0, 0, 1, 0, 32'h11);
    cycle("err.push", 0, 0, 0, 1, 0, 32'h22);
    cycle("err.fd",   0, 0, 0, 0, 1, 32'h0);
    cycle("err.rdy_push", 0, 0, 0, 1, 0, 32'h99);
    repeat (3) cycle("err.pop", 0, 0, 1, 0, 0, 32'h0);
    cycle("err.tx", 0, 1, 0, 0, 0, 32'h0);

    // async reset mid-drain, then Clear_buff during FILL
    for (int i = 0; i < 3; i++) cycle("rst.push", 0, 0, 0, 1, 0, 32'h300 + 32'(i));
    cycle("rst.fd",  0, 0, 0, 0, 1, 32'h0);
    cycle("rst.pop", 0, 0, 1, 0, 0, 32'h0);
    async_reset("rst.async");
    idle();
    for (int i = 0; i < 4; i++) cycle("clr.push", 0, 0, 0, 1, 0, 32'h400 + 32'(i));
    cycle("clr.pop_fill", 0, 0, 1, 0, 0, 32'h0);
    cycle("clr.clr", 1, 0, 0, 0, 0, 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned op;
      logic [31:0] d;
      op = $urandom_range(0, 999);
      d  = $urandom();
      if (op < 3) begin
        async_reset("rnd.async");
      end else begin
        op = op % 100;
        if (!m_closed) begin
          if      (op < 65) cycle("rnd.push",  0, 0, 0, 1, 0, d);
          else if (op < 70) cycle("rnd.pfd",   0, 0, 0, 1, 1, d);
          else if (op < 78) cycle("rnd.fd",    0, 0, 0, 0, 1, d);
          else if (op < 82) cycle("rnd.pop",   0, 0, 1, 0, 0, d);
          else if (op < 86) cycle("rnd.tx",    0, 1, 0, 0, 0, d);
          else if (op < 88) cycle("rnd.clr",   1, 0, 0, 0, 0, d);
          else              cycle("rnd.idle",  0, 0, 0, 0, 0, d);
        end else begin
          if      (op < 60) cycle("rnd.pop",   0, 0, 1, 0, 0, d);
          else if (op < 70) cycle("rnd.tx",    0, 1, 0, 0, 0, d);
          else if (op < 78) cycle("rnd.push",  0, 0, 0, 1, 0, d);
          else if (op < 80) cycle("rnd.clr",   1, 0, 0, 0, 0, d);
          else if (op < 85) cycle("rnd.fd",    0, 0, 0, 0, 1, d);
          else              cycle("rnd.idle",  0, 0, 0, 0, 0, d);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_filo.md
RESULT_FILO -- requirements
Module: result_filo

Interface
REQ-001 Parameter FILO_DEPTH, default FILO_DEPTH from ahim_config_pkg (32), number of stored lines; legal range 2..255.
REQ-002 clk_in  input  1  single clock; all logic on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Clear_buff  input  1  synchronous flush of contents, state and flags.
REQ-005 push  input  1  write strobe for push_data; one line per cycle.
REQ-006 push_data  input  PIO_DATA_WIDTH  result line to store.
REQ-007 frame_done  input  1  single-cycle pulse; closes the current frame.
REQ-008 pop  input  1  consumer removes the top line.
REQ-009 tx_done  input  1  consumer finished the frame; releases the buffer.
REQ-010 filo_q  output  PIO_DATA_WIDTH  top-of-stack line, combinational.
REQ-011 headcount  output  UINT8_WIDTH  line count latched at frame close.
REQ-012 tx_ready  output  1  frame closed and available to the consumer (drives tx_en).
REQ-013 full  output  1  stack holds FILO_DEPTH lines.
REQ-014 empty  output  1  stack holds zero lines.
REQ-015 overflow  output  1  sticky error: push dropped.
REQ-016 underflow  output  1  sticky error: pop while empty.

Function
REQ-017 Storage SHALL be a register array of FILO_DEPTH x PIO_DATA_WIDTH with stack pointer sp, width $clog2(FILO_DEPTH)+1, valued 0..FILO_DEPTH.
REQ-018 States SHALL be FILL, READY and DRAIN, each with a one-hot or encoded enum.
REQ-019 In FILL, push with !full SHALL write mem[sp] and increment sp next cycle; push with full SHALL be dropped and set overflow.
REQ-020 In FILL, frame_done with sp>0 (after any same-cycle push) SHALL latch headcount=sp (zero-extended), enter READY and assert tx_ready from the next cycle.
REQ-021 frame_done with sp==0 and no same-cycle push SHALL be ignored; the state stays FILL.
REQ-022 push in READY or DRAIN SHALL be dropped and set overflow; contents SHALL NOT change.
REQ-023 filo_q SHALL equal mem[sp-1] when !empty and 0 when empty, with zero-cycle latency.
REQ-024 pop in READY or DRAIN with !empty SHALL decrement sp next cycle; the first pop SHALL move READY to DRAIN.
REQ-025 pop while empty or in FILL SHALL be ignored and set underflow.
REQ-026 tx_done in READY or DRAIN SHALL, next cycle, set sp=0, headcount=0 and tx_ready=0 and enter FILL; unpopped lines SHALL be discarded.
REQ-027 tx_done in FILL SHALL be ignored.
REQ-028 Priority SHALL be Clear_buff > tx_done > pop > push; frame_done SHALL act only in FILL.
REQ-029 tx_ready SHALL be 1 exactly in READY and DRAIN; headcount SHALL hold steady while tx_ready=1.
REQ-030 full and empty SHALL be decoded combinationally from sp.
REQ-031 Clear_buff SHALL, next cycle, give sp=0, state FILL, headcount=0, tx_ready=0, overflow=0 and underflow=0.

Reset
REQ-032 rst_n low SHALL asynchronously force state FILL, sp=0, headcount=0, tx_ready=0, overflow=0 and underflow=0, giving empty=1, full=0 and filo_q=0.
REQ-033 Reset asserted mid-frame SHALL discard all lines; no partial frame SHALL survive reset.
REQ-034 The memory array SHALL NOT need reset; filo_q masking per REQ-023 SHALL hide stale data.

Structure
REQ-035 FILO_DEPTH, PIO_DATA_WIDTH, UINT8_WIDTH and the state enum typedef SHALL reside in ahim_config_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the controller and pointer SHALL be in one sequential process.

Verification
REQ-037 Push 0xA1,0xA2,0xA3, then frame_done -> headcount=3 and tx_ready=1 next cycle; filo_q=0xA3; three pops give 0xA2, 0xA1, then empty=1 and filo_q=0.
REQ-038 Push FILO_DEPTH+2 lines -> full=1 after line FILO_DEPTH, overflow=1, headcount=FILO_DEPTH after frame_done, and the top equals line FILO_DEPTH.
REQ-039 Same-cycle push 0x55 and frame_done with sp=1 -> headcount=2 and filo_q=0x55.
REQ-040 In DRAIN with 2 lines left, tx_done -> sp=0, tx_ready=0, state FILL; a following push 0x77 is accepted.
REQ-041 Push in READY -> overflow=1 and contents unchanged; pop while empty in DRAIN -> underflow=1 and sp stays 0.
REQ-042 Assert rst_n low mid-DRAIN, then Clear_buff during FILL with 4 lines -> all outputs at reset values asynchronously, and empty=1 and flags cleared on the next cycle.
